psram_qspi_responder: RTL and testbench
=======================================

# psram_qspi_responder

Synthesizable QSPI PSRAM device model that answers the APB PSRAM controller's pin-level traffic (`sck`, `ce_n`, quad data), backed by an internal byte array. It sits on the far side of the `qspi_*` pads in SoC simulation and FPGA bring-up, replacing an external PSRAM chip. It oversamples `sck`/`ce_n` with the system clock, decodes the command sequences, and returns read data on the shared data lines with tri-state control split into in/out/enable ports.

## Interface
- `ADDR_W`, default 12: byte-address width of the internal array (2^ADDR_W bytes); incoming 24-bit addresses are taken modulo 2^ADDR_W.
- `DUMMY`, default 6: wait cycles (sck periods) between address and first read nibble.
- `clock`  in  1  system clock; must be at least 8x the sck frequency.
- `reset`  in  1  asynchronous, active-low reset.
- `sck`  in  1  QSPI serial clock from the controller (asynchronous to `clock`).
- `ce_n`  in  1  chip enable, active low (asynchronous to `clock`).
- `dio_i`  in  4  data lines as seen at the pad.
- `dio_o`  out  4  data driven by the responder.
- `dio_oe`  out  4  per-line output enable (1 = drive).
- `qpi_mode`  out  1  1 once the Enter-QPI command (0x35) has been accepted.

## Operation
- `sck` and `ce_n` each pass through a 2-flop synchronizer. Edge detect is on the synchronized `sck`: rise = sample `dio_i`, fall = update `dio_o`. `dio_i` is sampled on the `clock` cycle the synchronized rise is seen; no extra sync is needed because data is stable around the sck rise.
- Synchronized `ce_n` high forces state IDLE from any state, clears the bit/nibble counters, and forces `dio_oe` = 0 on the next `clock` edge (abort).
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE -> CMD on synchronized `ce_n` falling.
- CMD:
  - SPI mode (`qpi_mode` = 0): 8 bits MSB-first on `dio_i[0]`, one per rise.
  - QPI mode: 2 nibbles, high nibble first.
- Command decode:
  - 0x35 in SPI mode: set `qpi_mode`, go to IGNORE.
  - 0xEB in QPI mode: go to ADDR, then read path.
  - 0x38 in QPI mode: go to ADDR, then write path.
  - Anything else: go to IGNORE.
- ADDR: 6 nibbles, MSB first, form a 24-bit address. Only the low ADDR_W bits are kept as the byte pointer.
  - Read path -> DUMMY; write path -> WDATA.
- DUMMY: count DUMMY rises -> RDATA.
- RDATA:
  - `dio_oe` = 4'hF. Each byte is sent high nibble then low nibble.
  - `dio_o` is updated on each detected sck fall, and on entry from DUMMY: the first nibble is driven at the fall following the last dummy rise.
  - The pointer increments after each low nibble is loaded, wrapping 2^ADDR_W-1 -> 0.
- WDATA: nibbles are collected high then low. On the low-nibble rise, the byte is written to mem[pointer] and the pointer increments with the same wrap. A lone high nibble at `ce_n` rise is discarded.
- IGNORE: consume edges, drive nothing, wait for `ce_n` high.
- `qpi_mode` is cleared only by reset. 0x35 received in QPI mode is ignored.

## Timing
- Reset values: state IDLE, `dio_o` = 0, `dio_oe` = 0, `qpi_mode` = 0, counters and pointer 0. Array contents are not reset.
- Reset assertion mid-transfer releases `dio_oe` asynchronously. After release, the responder waits for a fresh `ce_n` fall.
- Input latency: a pin edge is acted on 3 `clock` cycles after it occurs (2 sync + 1 edge register).
- `dio_o` is valid no later than 4 `clock` cycles after the sck fall, which is before the next sck rise given the 8x ratio.
- `dio_oe` rises with the first RDATA nibble and falls within 4 `clock` cycles of `ce_n` rising.
- Read data reflects a byte written earlier in the same or a prior transaction. A write-then-read of the same byte within one transaction cannot occur.

## Test plan
- Enter QPI: reset, SPI command 0x35 on `dio_i[0]`, `ce_n` high -> `qpi_mode` = 1, `dio_oe` stays 0 throughout.
- Write/read: QPI 0x38 addr 0x000010, data 0xDE,0xAD,0xBE,0xEF; then 0xEB addr 0x000010 with 6 dummies -> nibbles D,E,A,D,B,E,E,F on `dio_o`, `dio_oe` = 4'hF only during data.
- Wrap: ADDR_W = 12, write 0x11,0x22 at 0x000FFF -> mem[0xFFF] = 0x11, mem[0x000] = 0x22; a read from 0xFFF returns the same pair.
- Abort: write 0x38 addr 0x20 with 3 nibbles (0xA,0xB,0xC) then `ce_n` high -> mem[0x20] = 0xAB, mem[0x21] unchanged; the next transaction decodes normally.
- Illegal command: QPI 0x9F -> IGNORE, no array change, `dio_oe` = 0 until `ce_n` high.
- Reset during RDATA: assert `reset` low mid-read -> `dio_oe` = 0 immediately, `qpi_mode` = 0, state IDLE after release.

Source files
------------

// File: rtl/psram_qspi_responder.sv
// QSPI/QPI PSRAM device model: oversamples sck/ce_n, decodes SPI 0x35 and QPI 0xEB/0x38
// transactions, and serves reads/writes from an internal 2^ADDR_W byte array.
module psram_qspi_responder #(
    parameter int ADDR_W = 12,
    parameter int DUMMY  = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] dio_i,
    output logic [3:0] dio_o,
    output logic [3:0] dio_oe,
    output logic       qpi_mode,
    output logic [2:0] o_dbg_state
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    localparam logic [7:0] LP_DUMMY_LAST = 8'(DUMMY - 1);

    state_t              r_state, w_next;
    logic                r_sck_s1, r_sck_s2, r_sck_d;
    logic                r_ce_s1, r_ce_s2, r_ce_d;
    logic [7:0]          r_cnt;
    logic [6:0]          r_cmd;
    logic [ADDR_W-5:0]   r_shift;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_is_write, r_nib_lo, r_qpi;
    logic [3:0]          r_wr_hi, r_dio_o, r_oe;
    logic [7:0]          r_mem [0:(1<<ADDR_W)-1];

    logic                w_rise, w_fall, w_ce_fall, w_ce_hi;
    logic [7:0]          w_cmd_byte;
    logic [ADDR_W-1:0]   w_addr;
    logic [7:0]          w_rd_byte;
    logic                w_cmd_done, w_addr_done, w_dummy_done;
    logic                w_load_nib, w_wr_byte, w_wr_hi;

    assign w_rise     = r_sck_s2 & ~r_sck_d;
    assign w_fall     = ~r_sck_s2 & r_sck_d;
    assign w_ce_fall  = ~r_ce_s2 & r_ce_d;
    assign w_ce_hi    = r_ce_s2;
    assign w_cmd_byte = r_qpi ? {r_cmd[3:0], dio_i} : {r_cmd, dio_i[0]};
    assign w_addr     = {r_shift, dio_i};
    assign w_rd_byte  = r_mem[r_ptr];

    assign w_cmd_done   = (r_state == ST_CMD) && w_rise && (r_qpi ? (r_cnt == 8'd1) : (r_cnt == 8'd7));
    assign w_addr_done  = (r_state == ST_ADDR) && w_rise && (r_cnt == 8'd5);
    assign w_dummy_done = (r_state == ST_DUMMY) && w_rise && (r_cnt == LP_DUMMY_LAST);

    // Sync flops reset low so a ce_n held low across reset never looks like a fresh fall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sck_s1 <= 1'b0; r_sck_s2 <= 1'b0; r_sck_d <= 1'b0;
            r_ce_s1  <= 1'b0; r_ce_s2  <= 1'b0; r_ce_d  <= 1'b0;
        end else begin
            r_sck_s1 <= sck;  r_sck_s2 <= r_sck_s1; r_sck_d <= r_sck_s2;
            r_ce_s1  <= ce_n; r_ce_s2  <= r_ce_s1;  r_ce_d  <= r_ce_s2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_ce_hi) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_ce_fall) w_next = ST_CMD;
                ST_CMD: begin
                    if (w_cmd_done) begin
                        if (r_qpi && (w_cmd_byte == 8'hEB || w_cmd_byte == 8'h38)) w_next = ST_ADDR;
                        else                                                        w_next = ST_IGNORE;
                    end
                end
                ST_ADDR:  if (w_addr_done) w_next = r_is_write ? ST_WDATA : ST_DUMMY;
                ST_DUMMY: if (w_dummy_done) w_next = ST_RDATA;
                default:  w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_load_nib  = (r_state == ST_RDATA) && w_fall && !w_ce_hi;
        w_wr_hi     = (r_state == ST_WDATA) && w_rise && !r_nib_lo && !w_ce_hi;
        w_wr_byte   = (r_state == ST_WDATA) && w_rise && r_nib_lo && !w_ce_hi;
        dio_o       = r_dio_o;
        dio_oe      = r_oe;
        qpi_mode    = r_qpi;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'd0; r_cmd <= 7'd0; r_shift <= '0; r_ptr <= '0;
            r_is_write <= 1'b0; r_nib_lo <= 1'b0; r_qpi <= 1'b0;
            r_wr_hi <= 4'd0; r_dio_o <= 4'd0; r_oe <= 4'd0;
        end else if (w_ce_hi) begin
            r_cnt <= 8'd0; r_nib_lo <= 1'b0; r_oe <= 4'd0; r_dio_o <= 4'd0;
        end else begin
            if (r_state != w_next) r_cnt <= 8'd0;
            else if (w_rise)       r_cnt <= r_cnt + 8'd1;
            if (w_rise && r_state == ST_CMD)  r_cmd <= w_cmd_byte[6:0];
            if (w_rise && r_state == ST_ADDR) r_shift <= w_addr[ADDR_W-5:0];
            if (w_cmd_done) begin
                if (!r_qpi && w_cmd_byte == 8'h35) r_qpi <= 1'b1;
                r_is_write <= (w_cmd_byte == 8'h38);
            end
            if (w_addr_done) r_ptr <= w_addr;
            if (w_wr_hi) begin
                r_wr_hi  <= dio_i;
                r_nib_lo <= 1'b1;
            end
            if (w_wr_byte) begin
                r_ptr    <= r_ptr + ADDR_W'(1);
                r_nib_lo <= 1'b0;
            end
            if (w_load_nib) begin
                r_dio_o  <= r_nib_lo ? w_rd_byte[3:0] : w_rd_byte[7:4];
                r_oe     <= 4'hF;
                r_nib_lo <= ~r_nib_lo;
                if (r_nib_lo) r_ptr <= r_ptr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_byte) r_mem[r_ptr] <= {r_wr_hi, dio_i};
    end
endmodule

// File: tb/tb_psram_qspi_responder.sv
// Bench for psram_qspi_responder: drives pin-level QSPI/QPI transactions and checks read
// nibbles against an expected-nibble queue, plus output-enable and mode behaviour.
module tb_psram_qspi_responder;
    localparam int ADDR_W = 12;
    localparam int DUMMY  = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sck   = 1'b0;
    logic       ce_n  = 1'b1;
    logic [3:0] dio_i = 4'd0;
    logic [3:0] dio_o, dio_oe;
    logic       qpi_mode;
    logic [2:0] dbg_state;

    int n_err = 0;
    int n_chk = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [23:0] waddr;
        logic [31:0] wdata;
        int          wn;
        logic [23:0] raddr;
        logic [31:0] rexp;
        int          rn;
    } vec_t;
    vec_t vecs[4];

    psram_qspi_responder #(.ADDR_W(ADDR_W), .DUMMY(DUMMY)) dut (
        .clock(clock), .reset(reset), .sck(sck), .ce_n(ce_n), .dio_i(dio_i),
        .dio_o(dio_o), .dio_oe(dio_oe), .qpi_mode(qpi_mode), .o_dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One sck period of 160 ns (16 system clocks); dio_o sampled just before the rise.
    task automatic clk_nib(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
        dio_i = d;
        #40;
        q  = dio_o;
        oe = dio_oe;
        sck = 1'b1;
        #80;
        sck = 1'b0;
        #40;
    endtask

    task automatic drv_nib(input logic [3:0] d);
        logic [3:0] q, oe;
        clk_nib(d, q, oe);
        chk("oe_off", 32'(oe), 32'h0);
    endtask

    task automatic spi_cmd(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) drv_nib({3'b000, b[i]});
    endtask

    task automatic qpi_byte(input logic [7:0] b);
        drv_nib(b[7:4]);
        drv_nib(b[3:0]);
    endtask

    task automatic qpi_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) drv_nib(a[i*4 +: 4]);
    endtask

    task automatic cs_begin();
        ce_n = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #40;
        ce_n = 1'b1;
        #60;
        chk("oe_release", 32'(dio_oe), 32'h0);
        #140;
    endtask

    task automatic push_bytes(input logic [31:0] bytes, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = bytes[31-8*i -: 8];
            exp_q.push_back(b[7:4]);
            exp_q.push_back(b[3:0]);
        end
    endtask

    task automatic read_pop(input int k);
        logic [3:0] q, oe, e;
        for (int i = 0; i < k; i++) begin
            clk_nib(4'd0, q, oe);
            chk("oe_rdata", 32'(oe), 32'hF);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_empty: got nibble %0h expected none queued", q);
            end else begin
                e = exp_q.pop_front();
                chk("rd_nib", 32'(q), 32'(e));
            end
        end
    endtask

    task automatic write_tx(input logic [23:0] a, input logic [31:0] bytes, input int n);
        cs_begin();
        qpi_byte(8'h38);
        qpi_addr(a);
        for (int i = 0; i < n; i++) qpi_byte(bytes[31-8*i -: 8]);
        cs_end();
    endtask

    task automatic read_start(input logic [23:0] a);
        cs_begin();
        qpi_byte(8'hEB);
        qpi_addr(a);
        repeat (DUMMY) drv_nib(4'd0);
    endtask

    task automatic read_tx(input logic [23:0] a, input logic [31:0] bytes, input int n);
        push_bytes(bytes, n);
        read_start(a);
        read_pop(2 * n);
        cs_end();
    endtask

    initial begin
        vecs[0] = '{waddr: 24'h000010, wdata: 32'hDEADBEEF, wn: 4, raddr: 24'h000010, rexp: 32'hDEADBEEF, rn: 4};
        vecs[1] = '{waddr: 24'h000FFF, wdata: 32'h11220000, wn: 2, raddr: 24'h000FFF, rexp: 32'h11220000, rn: 2};
        vecs[2] = '{waddr: 24'h001000, wdata: 32'h33000000, wn: 1, raddr: 24'h000FFF, rexp: 32'h11330000, rn: 2};
        vecs[3] = '{waddr: 24'hABC100, wdata: 32'h77889900, wn: 3, raddr: 24'h000101, rexp: 32'h88990000, rn: 2};

        #50;
        chk("rst_oe", 32'(dio_oe), 32'h0);
        chk("rst_dio_o", 32'(dio_o), 32'h0);
        chk("rst_qpi", 32'(qpi_mode), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);
        reset = 1'b1;
        #100;

        // Enter QPI from SPI mode.
        cs_begin();
        spi_cmd(8'h35);
        #40;
        chk("enter_ignore", 32'(dbg_state), 32'h6);
        cs_end();
        chk("qpi_set", 32'(qpi_mode), 32'h1);

        for (int v = 0; v < 4; v++) begin
            write_tx(vecs[v].waddr, vecs[v].wdata, vecs[v].wn);
            read_tx(vecs[v].raddr, vecs[v].rexp, vecs[v].rn);
        end

        // Aborted write leaves a lone high nibble which must be dropped.
        write_tx(24'h000020, 32'h55660000, 2);
        cs_begin();
        qpi_byte(8'h38);
        qpi_addr(24'h000020);
        drv_nib(4'hA);
        drv_nib(4'hB);
        drv_nib(4'hC);
        cs_end();
        read_tx(24'h000020, 32'hAB660000, 2);

        // Illegal command and a repeated 0x35 in QPI are both ignored.
        cs_begin();
        qpi_byte(8'h9F);
        repeat (8) drv_nib(4'h5);
        chk("illegal_ignore", 32'(dbg_state), 32'h6);
        cs_end();
        cs_begin();
        qpi_byte(8'h35);
        chk("qpi35_ignore", 32'(dbg_state), 32'h6);
        cs_end();
        chk("qpi_kept", 32'(qpi_mode), 32'h1);
        read_tx(24'h000010, 32'hDEADBEEF, 4);

        // Reset in the middle of a read.
        push_bytes(32'hDE000000, 1);
        read_start(24'h000010);
        read_pop(2);
        #20;
        reset = 1'b0;
        #1;
        chk("rst_mid_oe", 32'(dio_oe), 32'h0);
        chk("rst_mid_qpi", 32'(qpi_mode), 32'h0);
        chk("rst_mid_state", 32'(dbg_state), 32'h0);
        #30;
        reset = 1'b1;
        #20;
        repeat (4) drv_nib(4'hF);
        chk("post_rst_idle", 32'(dbg_state), 32'h0);
        cs_end();
        cs_begin();
        spi_cmd(8'h35);
        cs_end();
        chk("qpi_reenter", 32'(qpi_mode), 32'h1);
        read_tx(24'h000012, 32'hBEEF0000, 2);

        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
